// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS funct codes, FSM states
// and funct classification helpers.
package muldiv_unit_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    endfunction

    function automatic logic is_div_op(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide
// unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [5:0]       i_control;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_start, i_control, i_op1, i_op2,
        input  o_busy, o_done, o_hi, o_lo, o_result
    );

    modport slave (
        input  i_start, i_control, i_op1, i_op2,
        output o_busy, o_done, o_hi, o_lo, o_result
    );

endinterface

// File: rtl/muldiv_unit_iter.sv
// Iteration datapath: one shift-add (multiply) or restore-subtract (divide) step
// per cycle on unsigned magnitudes, plus the step counter.
module muldiv_unit_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // hi is the running upper product / partial remainder; lo holds the
    // multiplier being consumed or the dividend being replaced by quotient bits.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, b_reg};
        diff    = shifted[WIDTH-1:0] - b_reg;
    end

    assign last = (count == CNT_W'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            b_reg <= '0;
            count <= '0;
        end else if (load) begin
            hi    <= '0;
            lo    <= a_in;
            b_reg <= b_in;
            count <= '0;
        end else if (step) begin
            count <= count + CNT_W'(1);
            if (is_div) begin
                hi <= ge ? diff : shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ge};
            end else begin
                {hi, lo} <= {sum, lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Optional MULDIV_EARLY_OUT_EN
// skips the iteration when either mul/div operand is zero.
//
// state   | meaning
// IDLE    | accepting requests; MTHI/MTLO write here
// CALC    | WIDTH iteration steps on operand magnitudes
// FIX     | sign fix-up / div-by-zero forcing, HI/LO written at exit
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    muldiv_unit_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] op1_raw;
    logic             busy_reg;
    logic             done_reg;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic             div_zero;
    logic             early;

    logic             accept_md;
    logic             step_en;
    logic             op_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic             it_last;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept_md = (state == ST_IDLE) && bus.i_start && is_muldiv(bus.i_control);
    assign step_en   = (state == ST_CALC);
    assign op_signed = is_signed_op(bus.i_control);
    assign a_abs     = (op_signed && bus.i_op1[WIDTH-1]) ? -bus.i_op1 : bus.i_op1;
    assign b_abs     = (op_signed && bus.i_op2[WIDTH-1]) ? -bus.i_op2 : bus.i_op2;

    muldiv_unit_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (accept_md),
        .step   (step_en),
        .is_div (is_div),
        .a_in   (a_abs),
        .b_in   (b_abs),
        .hi     (it_hi),
        .lo     (it_lo),
        .last   (it_last)
    );

    // Negating the magnitude restores truncate-toward-zero quotient and a
    // dividend-signed remainder; 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        prod     = {it_hi, it_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quot_fix = (neg_a ^ neg_b) ? -it_lo : it_lo;
        rem_fix  = neg_a ? -it_hi : it_hi;
        fix_hi   = '0;
        fix_lo   = '0;
        if (is_div && div_zero) begin
            fix_hi = op1_raw;
            fix_lo = '1;
        end else if (early) begin
            fix_hi = '0;
            fix_lo = '0;
        end else if (is_div) begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end else begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            hi_reg   <= '0;
            lo_reg   <= '0;
            op1_raw  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            early    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (is_muldiv(bus.i_control)) begin
                            is_div   <= is_div_op(bus.i_control);
                            neg_a    <= op_signed && bus.i_op1[WIDTH-1];
                            neg_b    <= op_signed && bus.i_op2[WIDTH-1];
                            op1_raw  <= bus.i_op1;
                            div_zero <= (bus.i_op2 == '0);
                            busy_reg <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                            if ((bus.i_op1 == '0) || (bus.i_op2 == '0)) begin
                                early <= 1'b1;
                                state <= ST_FIX;
                            end else begin
                                early <= 1'b0;
                                state <= ST_CALC;
                            end
`else
                            early <= 1'b0;
                            state <= ST_CALC;
`endif
                        end else if (bus.i_control == FUNCT_MTHI) begin
                            hi_reg <= bus.i_op1;
                        end else if (bus.i_control == FUNCT_MTLO) begin
                            lo_reg <= bus.i_op1;
                        end
                    end
                end
                ST_CALC: begin
                    if (it_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_reg   <= fix_hi;
                    lo_reg   <= fix_lo;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_result = '0;
        if (bus.i_control == FUNCT_MFHI) begin
            bus.o_result = hi_reg;
        end else if (bus.i_control == FUNCT_MFLO) begin
            bus.o_result = lo_reg;
        end
    end

    assign bus.o_busy = busy_reg;
    assign bus.o_done = done_reg;
    assign bus.o_hi   = hi_reg;
    assign bus.o_lo   = lo_reg;

endmodule
